// File: rtl/pass_verifier.sv
// pass_verifier: keypad password checker with timed unlock, failure counting, entry timeout and optional lockout
// Build option: define LOCKOUT_EN to include the lockout state and its timer; otherwise locked_out is tied low.
// Ports: clk, reset (sync, active-high); key_valid/key_digit/key_clear from the keypad decoder;
//   password (first digit in MSBs); unlock, pass_ok, pass_fail, locked_out, digit_count, fail_count
//   to the lock actuator and status display. All outputs are registered.
module pass_verifier #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_FAIL       = 3,
  parameter int OPEN_CYCLES    = 1000,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             key_valid,
  input  logic [DIGIT_W-1:0]               key_digit,
  input  logic                             key_clear,
  input  logic [DIGITS*DIGIT_W-1:0]        password,
  output logic                             unlock,
  output logic                             pass_ok,
  output logic                             pass_fail,
  output logic                             locked_out,
  output logic [$clog2(DIGITS+1)-1:0]      digit_count,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_count
);
  localparam int PW = DIGITS * DIGIT_W;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int OW = $clog2(OPEN_CYCLES + 1);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_t;
  state_t         state_q, state_d;
  logic [PW-1:0]  entry_q, entry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]  fail_q, fail_d, fail_inc;
  logic [OW-1:0]  open_t_q, open_t_d;
  logic [TW-1:0]  idle_q, idle_d;
  logic           unlock_q, unlock_d, ok_q, ok_d, bad_q, bad_d;
`ifdef LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0]  lock_t_q, lock_t_d;
  logic           lock_q, lock_d;
`endif
  assign fail_inc = fail_q == FW'(MAX_FAIL) ? fail_q : fail_q + 1'b1;
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    open_t_d = open_t_q;
    idle_d   = idle_q;
    unlock_d = unlock_q;
    ok_d     = 1'b0;
    bad_d    = 1'b0;
`ifdef LOCKOUT_EN
    lock_t_d = lock_t_q;
    lock_d   = lock_q;
`endif
    case (state_q)
      ENTRY: begin
        // a full buffer is handed to CHECK on the following edge; keys are not taken meanwhile
        if (cnt_q == CW'(DIGITS)) begin
          state_d = CHECK;
          idle_d  = '0;
        end else if (key_clear) begin
          entry_d = '0;
          cnt_d   = '0;
          idle_d  = '0;
        end else if (key_valid) begin
          entry_d = (entry_q << DIGIT_W) | PW'(key_digit);
          cnt_d   = cnt_q + 1'b1;
          idle_d  = '0;
        end else if (TIMEOUT_CYCLES > 0 && cnt_q != '0) begin
          idle_d  = idle_q == TW'(TIMEOUT_CYCLES - 1) ? '0 : idle_q + 1'b1;
          entry_d = idle_q == TW'(TIMEOUT_CYCLES - 1) ? '0 : entry_q;
          cnt_d   = idle_q == TW'(TIMEOUT_CYCLES - 1) ? '0 : cnt_q;
        end
      end
      CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (entry_q == password) begin
          state_d  = OPEN;
          ok_d     = 1'b1;
          unlock_d = 1'b1;
          fail_d   = '0;
          open_t_d = '0;
        end else begin
          state_d = ENTRY;
          bad_d   = 1'b1;
          fail_d  = fail_inc;
`ifdef LOCKOUT_EN
          if (fail_inc == FW'(MAX_FAIL)) begin
            state_d  = LOCKOUT;
            lock_d   = 1'b1;
            lock_t_d = '0;
          end
`endif
        end
      end
      OPEN: begin
        if (key_clear || open_t_q == OW'(OPEN_CYCLES - 1)) begin
          state_d  = ENTRY;
          unlock_d = 1'b0;
          open_t_d = '0;
        end else begin
          open_t_d = open_t_q + 1'b1;
        end
      end
`ifdef LOCKOUT_EN
      LOCKOUT: begin
        if (lock_t_q == LW'(LOCKOUT_CYCLES - 1)) begin
          state_d  = ENTRY;
          lock_d   = 1'b0;
          lock_t_d = '0;
          fail_d   = '0;
        end else begin
          lock_t_d = lock_t_q + 1'b1;
        end
      end
`endif
      default: state_d = ENTRY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ENTRY;
      entry_q  <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      open_t_q <= '0;
      idle_q   <= '0;
      unlock_q <= 1'b0;
      ok_q     <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      open_t_q <= open_t_d;
      idle_q   <= idle_d;
      unlock_q <= unlock_d;
      ok_q     <= ok_d;
      bad_q    <= bad_d;
    end
  end
`ifdef LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_t_q <= '0;
      lock_q   <= 1'b0;
    end else begin
      lock_t_q <= lock_t_d;
      lock_q   <= lock_d;
    end
  end
  assign locked_out = lock_q;
`else
  assign locked_out = 1'b0;
`endif
  assign unlock      = unlock_q;
  assign pass_ok     = ok_q;
  assign pass_fail   = bad_q;
  assign digit_count = cnt_q;
  assign fail_count  = fail_q;
endmodule

// File: tb/tb_pass_verifier.sv
// tb_pass_verifier: directed and randomized checks of pass_verifier against an entry-level outcome model
module tb_pass_verifier;
  localparam int OPEN = 10;
  localparam int LOCK = 20;
  localparam int TMO  = 50;
  localparam int MAXF = 3;
  logic        clk = 0;
  logic        reset = 1;
  logic        key_valid = 0;
  logic [3:0]  key_digit = 0;
  logic        key_clear = 0;
  logic [15:0] pw = 16'h1234;
  logic        unlock, pass_ok, pass_fail, locked_out;
  logic [2:0]  digit_count;
  logic [1:0]  fail_count;
  int          errors = 0;
  int          checks = 0;
  int          fails = 0;
  bit          lock_en;
  pass_verifier #(
    .DIGITS(4), .DIGIT_W(4), .MAX_FAIL(MAXF), .OPEN_CYCLES(OPEN),
    .LOCKOUT_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .password(pw), .unlock(unlock), .pass_ok(pass_ok),
    .pass_fail(pass_fail), .locked_out(locked_out), .digit_count(digit_count),
    .fail_count(fail_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic press(input logic [3:0] d);
    key_valid = 1;
    key_digit = d;
    @(negedge clk);
    key_valid = 0;
  endtask
  task automatic enter(input logic [15:0] code, input int max_gap);
    for (int d = 0; d < 4; d++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      press(code[15-4*d -: 4]);
    end
  endtask
  task automatic check_all_zero(input string tag);
    chk({tag, "_unlock"}, 32'(unlock), 0);
    chk({tag, "_ok"}, 32'(pass_ok), 0);
    chk({tag, "_fail"}, 32'(pass_fail), 0);
    chk({tag, "_locked"}, 32'(locked_out), 0);
    chk({tag, "_cnt"}, 32'(digit_count), 0);
    chk({tag, "_fcnt"}, 32'(fail_count), 0);
  endtask
  // Called at the falling edge right after the last digit was sampled.
  task automatic finish_entry(input logic [15:0] code);
    logic m;
    m = (code == pw);
    chk("cnt_full", 32'(digit_count), 4);
    @(negedge clk);
    chk("early_ok", 32'(pass_ok), 0);
    chk("early_fail", 32'(pass_fail), 0);
    @(negedge clk);
    chk("pass_ok", 32'(pass_ok), 32'(m));
    chk("pass_fail", 32'(pass_fail), 32'(!m));
    if (m) fails = 0;
    else if (fails < MAXF) fails++;
    chk("fail_count", 32'(fail_count), 32'(fails));
    chk("cnt_cleared", 32'(digit_count), 0);
    if (m) begin
      for (int i = 0; i < OPEN; i++) begin
        chk("unlock_hold", 32'(unlock), 1);
        if (i == 1) chk("ok_pulse_end", 32'(pass_ok), 0);
        key_valid = 1'($urandom_range(0, 1));
        key_digit = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      key_valid = 0;
      chk("unlock_end", 32'(unlock), 0);
      chk("open_keys_ignored", 32'(digit_count), 0);
    end else if (lock_en && fails == MAXF) begin
      for (int i = 0; i < LOCK; i++) begin
        chk("locked_hold", 32'(locked_out), 1);
        chk("locked_cnt", 32'(digit_count), 0);
        key_valid = 1'(i % 2);
        key_digit = 4'((i / 2) % 4 + 1);
        @(negedge clk);
      end
      key_valid = 0;
      fails = 0;
      chk("locked_end", 32'(locked_out), 0);
      chk("locked_fcnt", 32'(fail_count), 0);
      chk("locked_keys_ignored", 32'(digit_count), 0);
    end else begin
      chk("fail_unlock", 32'(unlock), 0);
      chk("fail_locked", 32'(locked_out), 0);
      @(negedge clk);
      chk("fail_pulse_end", 32'(pass_fail), 0);
    end
  endtask
  initial begin
`ifdef LOCKOUT_EN
    lock_en = 1;
`else
    lock_en = 0;
`endif
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 0;
    @(negedge clk);
    enter(16'h1234, 0); finish_entry(16'h1234);
    enter(16'h1235, 2); finish_entry(16'h1235);
    enter(16'h1111, 1); finish_entry(16'h1111);
    enter(16'h9999, 0); finish_entry(16'h9999);
    enter(16'h1234, 1); finish_entry(16'h1234);
    for (int k = 0; k < 4; k++) begin
      enter(16'h4321, 1); finish_entry(16'h4321);
    end
    chk("fcnt_after_four", 32'(fail_count), lock_en ? 1 : 3);
    enter(16'h1234, 0); finish_entry(16'h1234);
    // idle timeout discards a partial entry
    enter(16'h0000, 0); finish_entry(16'h0000);
    press(1); press(2);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_before", 32'(digit_count), 2);
    @(negedge clk);
    chk("tmo_after", 32'(digit_count), 0);
    chk("tmo_fcnt", 32'(fail_count), 32'(fails));
    chk("tmo_no_fail", 32'(pass_fail), 0);
    enter(16'h1234, 3); finish_entry(16'h1234);
    // clear beats a simultaneous digit
    press(1); press(2);
    key_valid = 1; key_digit = 3; key_clear = 1;
    @(negedge clk);
    key_valid = 0; key_clear = 0;
    chk("clear_cnt", 32'(digit_count), 0);
    enter(16'h1234, 0);
    chk("cnt_full", 32'(digit_count), 4);
    repeat (2) @(negedge clk);
    chk("clr_open_ok", 32'(pass_ok), 1);
    repeat (3) @(negedge clk);
    chk("clr_open_hold", 32'(unlock), 1);
    key_clear = 1;
    @(negedge clk);
    key_clear = 0;
    chk("clr_open_drop", 32'(unlock), 0);
    fails = 0;
    enter(16'h1236, 0); finish_entry(16'h1236);
    // reset mid-entry and during open
    press(1); press(2);
    reset = 1;
    @(negedge clk);
    check_all_zero("rst_entry");
    reset = 0;
    fails = 0;
    enter(16'h1234, 0);
    repeat (4) @(negedge clk);
    chk("rst_open_pre", 32'(unlock), 1);
    reset = 1;
    @(negedge clk);
    check_all_zero("rst_open");
    reset = 0;
    @(negedge clk);
    chk("rst_open_stays", 32'(unlock), 0);
    // random passwords, codes and key spacing
    for (int k = 0; k < 16; k++) begin
      logic [15:0] code;
      pw = 16'($urandom);
      code = ($urandom_range(0, 2) == 0) ? 16'($urandom) : pw;
      enter(code, 4);
      finish_entry(code);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
